// File: rtl/dummy_acc_arb_pkg.sv
// Shared types for the accelerator arbiter: FSM states and index-width helper.
package dummy_acc_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Width of a requester index (IdxType = logic [idx_width(NUM_REQ)-1:0]).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dummy_acc_id_fifo.sv
// In-order FIFO of requester indices; one entry per transaction in flight.
module dummy_acc_id_fifo
    import dummy_acc_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr, w_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rptr];
    assign w_wr    = push_i && !full_o;
    assign w_rd    = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= ptr_inc(r_wptr);
            if (w_rd) r_rptr <= ptr_inc(r_rptr);
            if (w_wr && !w_rd)      r_count <= r_count + CNT_W'(1);
            else if (w_rd && !w_wr) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/dummy_accelerator_arbiter.sv
// Round-robin arbiter sharing one accelerator among NUM_REQ requesters;
// results are steered back in order using an ID FIFO.
module dummy_accelerator_arbiter
    import dummy_acc_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  WIDTH      = 32,
    parameter int  IMM_WIDTH  = 11,
    parameter type TagType    = logic,
    parameter int  FIFO_DEPTH = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]       req_rs1_i,
    input  logic [NUM_REQ-1:0][IMM_WIDTH-1:0]   req_imm_i,
    input  TagType [NUM_REQ-1:0]                req_tag_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    input  logic [NUM_REQ-1:0]                  rsp_ready_i,
    output logic [WIDTH-1:0]                    rsp_result_o,
    output TagType                              rsp_tag_o,
    output logic                                acc_valid_o,
    input  logic                                acc_ready_i,
    output logic [WIDTH-1:0]                    acc_rs1_o,
    output logic [IMM_WIDTH-1:0]                acc_imm_o,
    output TagType                              acc_tag_o,
    input  logic                                acc_valid_i,
    output logic                                acc_ready_o,
    input  logic [WIDTH-1:0]                    acc_result_i,
    input  TagType                              acc_tag_i,
    output logic                                acc_flush_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     inflight_o,
    output logic                                proto_err_o
);
    localparam int IDX_W = idx_width(NUM_REQ);
    typedef logic [IDX_W-1:0] IdxType;

    arb_state_e           r_state, w_state_nxt;
    IdxType               r_grant, w_grant_nxt;
    IdxType               r_rr_ptr, w_rr_nxt;
    IdxType               w_win, w_sel, w_head;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic                 w_found, w_any, w_push, w_pop, w_full, w_empty;
    logic                 r_proto_err;

    // Search the doubled request vector from rr_ptr so the wrap needs no mask pass.
    always_comb begin
        w_dbl   = {req_valid_i, req_valid_i};
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            if (!w_found && i >= int'(r_rr_ptr) && w_dbl[i]) begin
                w_found = 1'b1;
                w_win   = IdxType'(i % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_sel       = (r_state == HOLD) ? r_grant : w_win;
        w_any       = (r_state == HOLD) || w_found;
        acc_valid_o = w_any && !w_full && !flush_i;
        req_ready_o = '0;
        if (acc_valid_o) req_ready_o[w_sel] = acc_ready_i;
        w_push      = acc_valid_o && acc_ready_i;
        if (flush_i) begin
            w_state_nxt = ARB;
            w_rr_nxt    = '0;
        end else if (w_push) begin
            w_state_nxt = ARB;
            w_rr_nxt    = (w_sel == IdxType'(NUM_REQ-1)) ? '0 : w_sel + IdxType'(1);
        end else if (acc_valid_o) begin
            w_state_nxt = HOLD;
            w_grant_nxt = w_sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ARB;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign acc_rs1_o = req_rs1_i[w_sel];
    assign acc_imm_o = req_imm_i[w_sel];
    assign acc_tag_o = req_tag_i[w_sel];

    dummy_acc_id_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_sel),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (inflight_o)
    );

    assign acc_ready_o = !w_empty && rsp_ready_i[w_head];
    assign w_pop       = acc_valid_i && acc_ready_o;

    always_comb begin
        rsp_valid_o = '0;
        if (acc_valid_i && !w_empty && !flush_i) rsp_valid_o[w_head] = 1'b1;
    end

    assign rsp_result_o = acc_result_i;
    assign rsp_tag_o    = acc_tag_i;
    assign acc_flush_o  = flush_i;

    // A response with nothing outstanding means the accelerator broke protocol.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                       r_proto_err <= 1'b0;
        else if (acc_valid_i && w_empty) r_proto_err <= 1'b1;
    end
    assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_dummy_accelerator_arbiter.sv
// Randomized + directed bench for dummy_accelerator_arbiter against a queue-based model.
module tb_dummy_accelerator_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int IMM_W   = 11;
    localparam int DEPTH   = 2;
    typedef logic [4:0] tag_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_i = 1'b0;
    logic [NUM_REQ-1:0] req_valid_i = '0;
    logic [NUM_REQ-1:0] req_ready_o;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_rs1_i = '0;
    logic [NUM_REQ-1:0][IMM_W-1:0] req_imm_i = '0;
    tag_t [NUM_REQ-1:0] req_tag_i = '0;
    logic [NUM_REQ-1:0] rsp_valid_o;
    logic [NUM_REQ-1:0] rsp_ready_i = '0;
    logic [WIDTH-1:0] rsp_result_o;
    tag_t rsp_tag_o;
    logic acc_valid_o;
    logic acc_ready_i = 1'b0;
    logic [WIDTH-1:0] acc_rs1_o;
    logic [IMM_W-1:0] acc_imm_o;
    tag_t acc_tag_o;
    logic acc_valid_i = 1'b0;
    logic acc_ready_o;
    logic [WIDTH-1:0] acc_result_i = '0;
    tag_t acc_tag_i = '0;
    logic acc_flush_o;
    logic [$clog2(DEPTH+1)-1:0] inflight_o;
    logic proto_err_o;

    dummy_accelerator_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IMM_WIDTH(IMM_W),
        .TagType(tag_t), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rs1_i(req_rs1_i), .req_imm_i(req_imm_i), .req_tag_i(req_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
        .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
        .acc_rs1_o(acc_rs1_o), .acc_imm_o(acc_imm_o), .acc_tag_o(acc_tag_o),
        .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
        .acc_result_i(acc_result_i), .acc_tag_i(acc_tag_i),
        .acc_flush_o(acc_flush_o), .inflight_o(inflight_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: outstanding requester ids in order, round-robin start, held grant, sticky error.
    int m_q[$];
    int m_rr = 0;
    bit m_hold = 0;
    int m_hg = 0;
    bit m_perr = 0;

    typedef struct {
        int sel;
        bit accv;
        bit accr;
        bit [NUM_REQ-1:0] rdy;
        bit [NUM_REQ-1:0] rv;
    } exp_t;

    function automatic exp_t calc();
        exp_t e;
        e.sel = -1; e.accv = 0; e.accr = 0; e.rdy = '0; e.rv = '0;
        if (m_hold) e.sel = m_hg;
        else
            for (int k = 0; k < NUM_REQ; k++)
                if (e.sel < 0 && req_valid_i[(m_rr + k) % NUM_REQ]) e.sel = (m_rr + k) % NUM_REQ;
        e.accv = (e.sel >= 0) && (m_q.size() < DEPTH) && !flush_i;
        if (e.accv && acc_ready_i) e.rdy[e.sel] = 1'b1;
        if (m_q.size() > 0) begin
            e.accr = rsp_ready_i[m_q[0]];
            if (acc_valid_i && !flush_i) e.rv[m_q[0]] = 1'b1;
        end
        return e;
    endfunction

    exp_t me;
    bit   m_was_empty;

    // Compare, then advance the model to what the coming clock edge produces.
    always @(negedge clk) begin
        if (rst) begin
            m_q.delete(); m_rr = 0; m_hold = 0; m_hg = 0; m_perr = 0;
        end else begin
            me = calc();
            chk("acc_valid", acc_valid_o, me.accv);
            chk("req_ready", req_ready_o, me.rdy);
            chk("rsp_valid", rsp_valid_o, me.rv);
            chk("acc_ready", acc_ready_o, me.accr);
            chk("inflight", inflight_o, m_q.size());
            chk("proto_err", proto_err_o, m_perr);
            chk("acc_flush", acc_flush_o, flush_i);
            chk("rsp_result", rsp_result_o, acc_result_i);
            chk("rsp_tag", rsp_tag_o, acc_tag_i);
            if (me.accv) begin
                chk("acc_rs1", acc_rs1_o, req_rs1_i[me.sel]);
                chk("acc_imm", acc_imm_o, req_imm_i[me.sel]);
                chk("acc_tag", acc_tag_o, req_tag_i[me.sel]);
            end
            m_was_empty = (m_q.size() == 0);
            if (acc_valid_i && m_was_empty) m_perr = 1;
            if (flush_i) begin
                m_q.delete(); m_rr = 0; m_hold = 0;
            end else begin
                if (acc_valid_i && me.accr) void'(m_q.pop_front());
                if (me.accv && acc_ready_i) begin
                    m_q.push_back(me.sel);
                    m_rr = (me.sel + 1) % NUM_REQ;
                    m_hold = 0;
                end else if (me.accv) begin
                    m_hold = 1;
                    m_hg = me.sel;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        flush_i = 0; req_valid_i = '0; rsp_ready_i = '0;
        acc_ready_i = 0; acc_valid_i = 0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_acc_valid"}, acc_valid_o, 0);
        chk({tag, "_req_ready"}, req_ready_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_acc_ready"}, acc_ready_o, 0);
        chk({tag, "_inflight"}, inflight_o, 0);
        chk({tag, "_proto_err"}, proto_err_o, 0);
        chk({tag, "_acc_flush"}, acc_flush_o, 0);
    endtask

    task automatic do_reset();
        idle(); rst = 1; cyc(); cyc(); rst = 0; cyc();
    endtask

    int got;
    logic [WIDTH-1:0] rs1_3;

    initial begin
        // Reset state
        idle(); rst = 1; cyc(); cyc(); #1;
        reset_checks("rst");
        rst = 0; cyc();

        // Single request from requester 2
        req_valid_i = 4'b0100; req_rs1_i[2] = 32'hA5A5_0002; acc_ready_i = 1; #1;
        chk("single_accv", acc_valid_o, 1);
        chk("single_rdy", req_ready_o, 4'b0100);
        chk("single_rs1", acc_rs1_o, 32'hA5A5_0002);
        cyc(); req_valid_i = '0; acc_ready_i = 0; #1;
        chk("single_inflight1", inflight_o, 1);
        cyc();
        acc_valid_i = 1; acc_result_i = 32'h0000_1234; rsp_ready_i = 4'b0100; #1;
        chk("single_rsp_valid", rsp_valid_o, 4'b0100);
        chk("single_acc_ready", acc_ready_o, 1);
        cyc(); acc_valid_i = 0; rsp_ready_i = '0; #1;
        chk("single_inflight0", inflight_o, 0);

        // Fairness: all valid, response drained each cycle
        do_reset();
        req_valid_i = 4'hF; acc_ready_i = 1; rsp_ready_i = 4'hF;
        for (int k = 0; k < 8; k++) begin
            acc_valid_i = (m_q.size() > 0); #1;
            got = -1;
            for (int r = 0; r < NUM_REQ; r++) if (req_ready_o == 4'(1 << r)) got = r;
            chk("fair_grant", got, k % NUM_REQ);
            cyc();
        end
        req_valid_i = '0; acc_valid_i = 1; cyc();
        acc_valid_i = 0; rsp_ready_i = '0; #1;
        chk("fair_drained", inflight_o, 0);

        // Stall/lock on requester 1 while 0 and 3 change around it
        req_valid_i = 4'b1010; req_rs1_i[1] = 32'h1111_0001; req_rs1_i[3] = 32'h3333_0003;
        acc_ready_i = 0;
        for (int s = 0; s < 5; s++) begin
            if (s >= 1) begin req_valid_i[0] = 1; req_rs1_i[3] = $urandom; end
            #1;
            chk("stall_accv", acc_valid_o, 1);
            chk("stall_rs1", acc_rs1_o, 32'h1111_0001);
            chk("stall_rdy", req_ready_o, 4'b0000);
            cyc();
        end
        acc_ready_i = 1; #1;
        chk("stall_accept1", req_ready_o, 4'b0010);
        cyc(); req_valid_i = 4'b1001; rs1_3 = req_rs1_i[3]; #1;
        chk("stall_next3", req_ready_o, 4'b1000);
        chk("stall_rs1_3", acc_rs1_o, rs1_3);
        cyc();

        // FIFO full, pop in cycle N, dispatch in N+1
        req_valid_i = 4'b0001; #1;
        chk("full_accv", acc_valid_o, 0);
        chk("full_inflight", inflight_o, 2);
        chk("full_rdy", req_ready_o, 4'b0000);
        cyc(); acc_valid_i = 1; rsp_ready_i = 4'b0010; #1;
        chk("popN_rsp", rsp_valid_o, 4'b0010);
        chk("popN_accv", acc_valid_o, 0);
        cyc(); acc_valid_i = 0; rsp_ready_i = '0; #1;
        chk("popN1_accv", acc_valid_o, 1);
        chk("popN1_rdy", req_ready_o, 4'b0001);
        chk("popN1_inflight", inflight_o, 1);
        cyc();

        // Build HOLD with one in flight and rr_ptr != 0, then flush
        acc_valid_i = 1; rsp_ready_i = 4'b1000; req_valid_i = 4'b0100; acc_ready_i = 0;
        cyc(); acc_valid_i = 0; rsp_ready_i = '0; #1;
        chk("hold_accv", acc_valid_o, 1);
        cyc();
        flush_i = 1; acc_valid_i = 1; rsp_ready_i = 4'hF; #1;
        chk("flush_acc_flush", acc_flush_o, 1);
        chk("flush_accv", acc_valid_o, 0);
        chk("flush_rdy", req_ready_o, 4'b0000);
        chk("flush_rsp", rsp_valid_o, 4'b0000);
        cyc(); flush_i = 0; acc_valid_i = 0; rsp_ready_i = '0;
        req_valid_i = 4'b0011; acc_ready_i = 1; #1;
        chk("postflush_inflight", inflight_o, 0);
        chk("postflush_flush", acc_flush_o, 0);
        chk("postflush_rr0", req_ready_o, 4'b0001);
        cyc();

        // Reset mid-transaction
        req_valid_i = 4'b0010; acc_ready_i = 0; cyc();
        rst = 1; idle(); #1;
        reset_checks("midrst");
        cyc(); rst = 0; cyc();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!(m_hold && m_hg == r)) begin
                    req_valid_i[r] = 1'($urandom_range(0, 1));
                    req_rs1_i[r]   = $urandom;
                    req_imm_i[r]   = IMM_W'($urandom);
                    req_tag_i[r]   = tag_t'($urandom);
                end
            end
            acc_ready_i  = ($urandom_range(0, 3) != 0);
            acc_valid_i  = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            rsp_ready_i  = NUM_REQ'($urandom);
            acc_result_i = $urandom;
            acc_tag_i    = tag_t'($urandom);
            flush_i      = ($urandom_range(0, 31) == 0);
            cyc();
        end

        // Protocol error: response with nothing outstanding, sticky across flush
        idle(); flush_i = 1; cyc(); flush_i = 0;
        rsp_ready_i = 4'hF; acc_valid_i = 1; #1;
        chk("perr_acc_ready", acc_ready_o, 0);
        chk("perr_rsp_valid", rsp_valid_o, 4'b0000);
        cyc(); acc_valid_i = 0; #1;
        chk("perr_set", proto_err_o, 1);
        flush_i = 1; cyc(); flush_i = 0; #1;
        chk("perr_after_flush", proto_err_o, 1);
        cyc(); #1;
        chk("perr_sticky", proto_err_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
